draw_scheduler: RTL and testbench

//  Queues draw commands (FILL, REULEAUX) and runs them one at a time on the fillscreen and

---
 rtl/draw_pkg.sv | 33 +++
 rtl/draw_scheduler_if.sv | 23 ++
 rtl/draw_cmd_fifo.sv | 70 +++++++
 rtl/draw_scheduler.sv | 158 +++++++++++++++
 tb/tb_draw_scheduler.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_pkg.sv
// Shared types for the draw command scheduler: opcodes, FSM encodings and the queued command record.
package draw_pkg;

  typedef enum logic {
    OP_FILL     = 1'b0,
    OP_REULEAUX = 1'b1
  } draw_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

  // Plain constants for the state register, matching sched_state_t encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef struct packed {
    draw_op_t    op;
    logic [2:0]  colour;
    logic [7:0]  cx;
    logic [6:0]  cy;
    logic [7:0]  diam;
  } draw_cmd_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

endpackage

// File: rtl/draw_scheduler_if.sv
// Command bus from the switch/key decode into the draw scheduler (valid/ready handshake).
interface draw_scheduler_if;
  import draw_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [2:0] cmd_colour;
  logic [7:0] cmd_cx;
  logic [6:0] cmd_cy;
  logic [7:0] cmd_diam;

  modport master (
    output cmd_valid, cmd_op, cmd_colour, cmd_cx, cmd_cy, cmd_diam,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_colour, cmd_cx, cmd_cy, cmd_diam,
    output cmd_ready
  );

endinterface

// File: rtl/draw_cmd_fifo.sv
// Command queue: RAM array with registered read, push/pop/flush, flush has priority over both.
module draw_cmd_fifo
  import draw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  draw_cmd_t                  wr_data,
  output draw_cmd_t                  rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  draw_cmd_t         mem [DEPTH];
  draw_cmd_t         rd_data_reg;
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]       count_reg, count_next;
  logic              push_ok, pop_ok;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = rd_data_reg;

  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_comb begin
    count_next = count_reg;
    if (flush)
      count_next = '0;
    else if (push_ok && !pop_ok)
      count_next = count_reg + 1'b1;
    else if (pop_ok && !push_ok)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      // Pointer wrap is free because DEPTH is a power of two
      if (flush)
        rd_ptr_reg <= wr_ptr_reg;
      else if (pop_ok)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= wr_data;
    if (pop_ok)
      rd_data_reg <= mem[rd_ptr_reg];
  end

endmodule

// File: rtl/draw_scheduler.sv
// Queues FILL/REULEAUX commands, runs them one at a time on the engines and owns the VGA plot port.
// Optional DRAW_SCHED_CLIP_EN: suppress plots that fall outside X_MAX x Y_MAX.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int X_MAX      = SCREEN_W,
  parameter int Y_MAX      = SCREEN_H
) (
  input  logic                          clk,
  input  logic                          rst_n,
  draw_scheduler_if.slave               cmd,
  input  logic                          flush,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   q_count,

  output logic                          fill_start,
  output logic [2:0]                    fill_colour,
  input  logic                          fill_done,
  input  logic [7:0]                    fill_x,
  input  logic [6:0]                    fill_y,
  input  logic [2:0]                    fill_col,
  input  logic                          fill_plot,

  output logic                          reu_start,
  output logic [2:0]                    reu_colour,
  output logic [7:0]                    reu_cx,
  output logic [6:0]                    reu_cy,
  output logic [7:0]                    reu_diam,
  input  logic                          reu_done,
  input  logic [7:0]                    reu_x,
  input  logic [6:0]                    reu_y,
  input  logic [2:0]                    reu_col,
  input  logic                          reu_plot,

  output logic [7:0]                    vga_x,
  output logic [6:0]                    vga_y,
  output logic [2:0]                    vga_colour,
  output logic                          vga_plot
);

`ifdef DRAW_SCHED_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [8:0] X_LIM = 9'(X_MAX);
  localparam logic [7:0] Y_LIM = 8'(Y_MAX);

  draw_cmd_t   wr_cmd, fifo_rd;
  logic        fifo_full, fifo_empty, pop;

  logic [1:0]  state_reg, state_next;
  draw_op_t    op_reg;
  logic [2:0]  colour_reg;
  logic [7:0]  cx_reg;
  logic [6:0]  cy_reg;
  logic [7:0]  diam_reg;
  logic        armed_reg;
  logic        sel_done, load_done;

  assign wr_cmd.op     = draw_op_t'(cmd.cmd_op);
  assign wr_cmd.colour = cmd.cmd_colour;
  assign wr_cmd.cx     = cmd.cmd_cx;
  assign wr_cmd.cy     = cmd.cmd_cy;
  assign wr_cmd.diam   = cmd.cmd_diam;

  assign cmd.cmd_ready = !fifo_full;
  assign pop = (state_reg == ST_IDLE) && !fifo_empty && !flush;

  draw_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cmd.cmd_valid),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_cmd),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (q_count)
  );

  assign sel_done  = (op_reg == OP_REULEAUX) ? reu_done : fill_done;
  assign load_done = (fifo_rd.op == OP_REULEAUX) ? reu_done : fill_done;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (pop) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_RUN;
      ST_RUN:   if (armed_reg && sel_done) state_next = ST_DRAIN;
      ST_DRAIN: if (!sel_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // A done that is already high when RUN begins must drop before it counts as completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      op_reg     <= OP_FILL;
      colour_reg <= '0;
      cx_reg     <= '0;
      cy_reg     <= '0;
      diam_reg   <= '0;
      armed_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_LOAD) begin
        op_reg     <= fifo_rd.op;
        colour_reg <= fifo_rd.colour;
        cx_reg     <= fifo_rd.cx;
        cy_reg     <= fifo_rd.cy;
        diam_reg   <= fifo_rd.diam;
        armed_reg  <= !load_done;
      end else if ((state_reg == ST_RUN) && !sel_done) begin
        armed_reg <= 1'b1;
      end
    end
  end

  assign fill_start  = (state_reg == ST_RUN) && (op_reg == OP_FILL);
  assign reu_start   = (state_reg == ST_RUN) && (op_reg == OP_REULEAUX);
  assign fill_colour = colour_reg;
  assign reu_colour  = colour_reg;
  assign reu_cx      = cx_reg;
  assign reu_cy      = cy_reg;
  assign reu_diam    = diam_reg;

  assign busy = (state_reg != ST_IDLE) || (q_count != '0);

  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    if (state_reg == ST_RUN) begin
      if (op_reg == OP_REULEAUX) begin
        vga_x      = reu_x;
        vga_y      = reu_y;
        vga_colour = reu_col;
        vga_plot   = reu_plot;
      end else begin
        vga_x      = fill_x;
        vga_y      = fill_y;
        vga_colour = fill_col;
        vga_plot   = fill_plot;
      end
      if (CLIP_EN && (({1'b0, vga_x} >= X_LIM) || ({1'b0, vga_y} >= Y_LIM)))
        vga_plot = 1'b0;
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler; engines are modelled by driving done/plot inputs by hand.
module tb_draw_scheduler;
  import draw_pkg::*;

`ifdef DRAW_SCHED_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       busy;
  logic [2:0] q_count;
  logic       fill_start, fill_done, fill_plot;
  logic [2:0] fill_colour, fill_col;
  logic [7:0] fill_x;
  logic [6:0] fill_y;
  logic       reu_start, reu_done, reu_plot;
  logic [2:0] reu_colour, reu_col;
  logic [7:0] reu_cx, reu_diam, reu_x;
  logic [6:0] reu_cy, reu_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int n_checks = 0;
  int n_errors = 0;

  draw_scheduler_if cmd_if ();

  draw_scheduler #(.FIFO_DEPTH(4), .X_MAX(160), .Y_MAX(120)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_if), .flush(flush), .busy(busy), .q_count(q_count),
    .fill_start(fill_start), .fill_colour(fill_colour), .fill_done(fill_done),
    .fill_x(fill_x), .fill_y(fill_y), .fill_col(fill_col), .fill_plot(fill_plot),
    .reu_start(reu_start), .reu_colour(reu_colour), .reu_cx(reu_cx), .reu_cy(reu_cy),
    .reu_diam(reu_diam), .reu_done(reu_done), .reu_x(reu_x), .reu_y(reu_y),
    .reu_col(reu_col), .reu_plot(reu_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic op, input logic [2:0] col, input logic [7:0] cx,
                           input logic [6:0] cy, input logic [7:0] d);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_op     = op;
    cmd_if.cmd_colour = col;
    cmd_if.cmd_cx     = cx;
    cmd_if.cmd_cy     = cy;
    cmd_if.cmd_diam   = d;
    $display("push op=%0d colour=%0d cx=%0d cy=%0d diam=%0d ready=%0d", op, col, cx, cy, d,
             cmd_if.cmd_ready);
  endtask

  task automatic push_cmd(input logic op, input logic [2:0] col, input logic [7:0] cx,
                          input logic [6:0] cy, input logic [7:0] d);
    drive_cmd(op, col, cx, cy, d);
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Wait for the next start, check which engine/colour, then complete it with a done pulse
  task automatic finish_current(input logic op, input logic [2:0] col, input logic [7:0] cx);
    int waited = 0;
    while (!(fill_start || reu_start) && waited < 20) begin
      step();
      waited++;
    end
    check("start_seen", 32'(fill_start || reu_start), 1);
    check("start_op", 32'(reu_start), 32'(op));
    check("start_colour", 32'(op ? reu_colour : fill_colour), 32'(col));
    if (op) check("reu_cx", 32'(reu_cx), 32'(cx));
    $display("run op=%0d colour=%0d after %0d cycles", op, col, waited);
    if (op) reu_done = 1'b1; else fill_done = 1'b1;
    step();
    check("drain_start_low", 32'(fill_start || reu_start), 0);
    reu_done  = 1'b0;
    fill_done = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 1'b0; cmd_if.cmd_colour = '0;
    cmd_if.cmd_cx = '0; cmd_if.cmd_cy = '0; cmd_if.cmd_diam = '0;
    fill_done = 0; fill_plot = 0; fill_x = '0; fill_y = '0; fill_col = '0;
    reu_done = 0; reu_plot = 0; reu_x = '0; reu_y = '0; reu_col = '0;
    step(); step();
    check("rst_busy", 32'(busy), 0);
    check("rst_qcount", 32'(q_count), 0);
    check("rst_ready", 32'(cmd_if.cmd_ready), 1);
    check("rst_starts", 32'(fill_start || reu_start), 0);
    check("rst_vga_plot", 32'(vga_plot), 0);
    rst_n = 1'b1;
    step();

    // 1: ordering, N+2 latency, done-high-on-entry; 4: mux tracking
    drive_cmd(1'b0, 3'b000, 8'd0, 7'd0, 8'd0);
    step();
    check("t1_q_after_push", 32'(q_count), 1);
    check("t1_no_start_n", 32'(fill_start), 0);
    drive_cmd(1'b1, 3'b010, 8'd80, 7'd60, 8'd40);
    step();
    cmd_if.cmd_valid = 1'b0;
    check("t1_q_pushpop", 32'(q_count), 1);
    check("t1_no_start_load", 32'(fill_start), 0);
    fill_plot = 1'b1;
    check("t4_plot_load", 32'(vga_plot), 0);
    step();
    check("t1_fill_start", 32'(fill_start), 1);
    check("t1_reu_idle", 32'(reu_start), 0);
    fill_x = 8'd10; fill_y = 7'd20; fill_col = 3'd5;
    reu_plot = 1'b1; reu_x = 8'd99; reu_col = 3'd1;
    #1;
    check("t4_vga_plot", 32'(vga_plot), 1);
    check("t4_vga_x", 32'(vga_x), 10);
    check("t4_vga_y", 32'(vga_y), 20);
    check("t4_vga_colour", 32'(vga_colour), 5);
    fill_plot = 1'b0;
    #1;
    check("t4_reu_plot_ignored", 32'(vga_plot), 0);
    reu_done = 1'b1;
    step(); step();
    check("t1_reu_done_ignored", 32'(fill_start), 1);
    reu_done = 1'b0; reu_plot = 1'b0;
    fill_done = 1'b1; fill_plot = 1'b1;
    step();
    check("t1_fill_drain", 32'(fill_start), 0);
    check("t4_plot_drain", 32'(vga_plot), 0);
    check("t1_reu_wait", 32'(reu_start), 0);
    fill_done = 1'b0;
    step();
    check("t4_plot_idle", 32'(vga_plot), 0);
    fill_plot = 1'b0;
    reu_done = 1'b1;
    step(); step();
    check("t1_reu_start", 32'(reu_start), 1);
    check("t1_reu_cx", 32'(reu_cx), 80);
    check("t1_reu_cy", 32'(reu_cy), 60);
    check("t1_reu_diam", 32'(reu_diam), 40);
    check("t1_reu_colour", 32'(reu_colour), 2);
    step();
    check("t1_stale_done", 32'(reu_start), 1);
    reu_done = 1'b0;
    step();
    reu_done = 1'b1;
    step();
    check("t1_reu_drain", 32'(reu_start), 0);
    check("t1_busy_drain", 32'(busy), 1);
    reu_done = 1'b0;
    step();
    check("t1_busy_idle", 32'(busy), 0);

    // 2: overfill while the first command runs
    push_cmd(1'b0, 3'd1, 8'd0, 7'd0, 8'd0);
    step(); step();
    push_cmd(1'b1, 3'd2, 8'd20, 7'd5, 8'd8);
    push_cmd(1'b0, 3'd3, 8'd30, 7'd5, 8'd8);
    push_cmd(1'b1, 3'd4, 8'd40, 7'd5, 8'd8);
    push_cmd(1'b0, 3'd5, 8'd50, 7'd5, 8'd8);
    check("t2_q_full", 32'(q_count), 4);
    check("t2_ready_low", 32'(cmd_if.cmd_ready), 0);
    push_cmd(1'b0, 3'd6, 8'd60, 7'd5, 8'd8);
    check("t2_q_still_full", 32'(q_count), 4);
    finish_current(1'b0, 3'd1, 8'd0);
    finish_current(1'b1, 3'd2, 8'd20);
    finish_current(1'b0, 3'd3, 8'd30);
    finish_current(1'b1, 3'd4, 8'd40);
    finish_current(1'b0, 3'd5, 8'd50);
    step(); step(); step();
    check("t2_no_extra", 32'(fill_start || reu_start), 0);
    check("t2_busy_end", 32'(busy), 0);

    // 3: flush with 3 queued, and flush beating a simultaneous push
    push_cmd(1'b0, 3'd7, 8'd0, 7'd0, 8'd0);
    step(); step();
    push_cmd(1'b0, 3'd1, 8'd0, 7'd0, 8'd0);
    push_cmd(1'b1, 3'd2, 8'd1, 7'd1, 8'd1);
    push_cmd(1'b0, 3'd3, 8'd0, 7'd0, 8'd0);
    check("t3_q3", 32'(q_count), 3);
    flush = 1'b1;
    drive_cmd(1'b1, 3'd4, 8'd2, 7'd2, 8'd2);
    step();
    flush = 1'b0; cmd_if.cmd_valid = 1'b0;
    check("t3_q_flushed", 32'(q_count), 0);
    check("t3_still_running", 32'(fill_start), 1);
    check("t3_colour_kept", 32'(fill_colour), 7);
    fill_done = 1'b1;
    step();
    check("t3_busy_drain", 32'(busy), 1);
    fill_done = 1'b0;
    step();
    check("t3_busy_idle", 32'(busy), 0);
    step(); step();
    check("t3_nothing_runs", 32'(fill_start || reu_start), 0);

    // 5: off-screen reuleaux plots
    push_cmd(1'b1, 3'd6, 8'd150, 7'd110, 8'd40);
    step(); step();
    check("t5_reu_start", 32'(reu_start), 1);
    reu_plot = 1'b1; reu_x = 8'd165; reu_y = 7'd50; reu_col = 3'd6;
    #1;
    check("t5_x_over", 32'(vga_plot), 32'(!CLIP));
    check("t5_x_pass", 32'(vga_x), 165);
    reu_x = 8'd159; reu_y = 7'd119;
    #1;
    check("t5_in_bounds", 32'(vga_plot), 1);
    reu_x = 8'd150; reu_y = 7'd120;
    #1;
    check("t5_y_over", 32'(vga_plot), 32'(!CLIP));
    reu_plot = 1'b0;
    finish_current(1'b1, 3'd6, 8'd150);

    // 6: asynchronous reset in the middle of a run
    push_cmd(1'b0, 3'd5, 8'd0, 7'd0, 8'd0);
    step(); step();
    push_cmd(1'b1, 3'd3, 8'd9, 7'd9, 8'd9);
    fill_plot = 1'b1;
    #1;
    check("t6_pre_plot", 32'(vga_plot), 1);
    check("t6_pre_q", 32'(q_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_start", 32'(fill_start), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_q", 32'(q_count), 0);
    check("t6_rst_plot", 32'(vga_plot), 0);
    check("t6_rst_colour", 32'(fill_colour), 0);
    check("t6_rst_ready", 32'(cmd_if.cmd_ready), 1);
    fill_plot = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    push_cmd(1'b1, 3'd4, 8'd77, 7'd33, 8'd20);
    finish_current(1'b1, 3'd4, 8'd77);
    check("t6_busy_end", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
